// File: rtl/fp_div.sv
`default_nettype none
// ============================================================================
//  Module   : fp_div
//  Purpose  : Iterative IEEE-754 binary32 divider (a / b). Special operands
//             finish in one cycle; normal operands use a restoring divider
//             producing one quotient bit per clock, then a round-to-nearest-
//             even step (27 cycles total). Denormals are flushed to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module fp_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_ROUND  = 2'd2
  } state_t;

  localparam logic [4:0]  C_LAST_ITER = 5'd25;
  localparam logic [31:0] C_QNAN      = 32'h7FC00000;

  state_t      state_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] result_q;
  logic        sign_q;
  logic [7:0]  ea_q;
  logic [7:0]  eb_q;
  logic [23:0] mb_q;
  logic [24:0] rem_q;
  logic [25:0] quo_q;
  logic [4:0]  cnt_q;

  // ---------------------------------------------------------------------------
  // Operand classification on the live inputs (used only in the accept cycle)
  // ---------------------------------------------------------------------------
  logic        w_sign;
  logic        w_a_zero, w_a_inf, w_a_nan;
  logic        w_b_zero, w_b_inf, w_b_nan;
  logic        w_special;
  logic [31:0] w_special_res;

  assign w_sign   = operand_a[31] ^ operand_b[31];
  assign w_a_zero = (operand_a[30:23] == 8'h00);
  assign w_b_zero = (operand_b[30:23] == 8'h00);
  assign w_a_inf  = (operand_a[30:23] == 8'hFF) && (operand_a[22:0] == 23'd0);
  assign w_b_inf  = (operand_b[30:23] == 8'hFF) && (operand_b[22:0] == 23'd0);
  assign w_a_nan  = (operand_a[30:23] == 8'hFF) && (operand_a[22:0] != 23'd0);
  assign w_b_nan  = (operand_b[30:23] == 8'hFF) && (operand_b[22:0] != 23'd0);

  // Special-case detection in priority order; first match wins
  always_comb begin
    w_special     = 1'b1;
    w_special_res = 32'h00000000;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_special_res = C_QNAN;
    end else if (w_a_inf || w_b_zero) begin
      w_special_res = {w_sign, 8'hFF, 23'd0};
    end else if (w_a_zero || w_b_inf) begin
      w_special_res = {w_sign, 31'd0};
    end else begin
      w_special = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // One restoring-division step. The remainder stays below 2*mb, so after the
  // conditional subtract it fits in 24 bits and the left shift loses nothing.
  // ---------------------------------------------------------------------------
  logic        w_rem_ge;
  logic [24:0] w_rem_sub;
  logic [24:0] rem_d;
  logic [25:0] quo_d;

  // Conditional subtract, then shift the remainder and append the quotient bit
  always_comb begin
    w_rem_ge  = (rem_q >= {1'b0, mb_q});
    w_rem_sub = w_rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
    rem_d     = {w_rem_sub[23:0], 1'b0};
    quo_d     = {quo_q[24:0], w_rem_ge};
  end

  // ---------------------------------------------------------------------------
  // Normalise, round to nearest even, and range-check the exponent
  // ---------------------------------------------------------------------------
  logic signed [9:0] w_exp_base;
  logic signed [9:0] w_exp_fin;
  logic [23:0]       w_mant_pre;
  logic [24:0]       w_mant_sum;
  logic [23:0]       w_mant_fin;
  logic              w_guard;
  logic              w_sticky;
  logic              w_inc;
  logic [31:0]       w_round_res;

  // Quotient lies in (0.5, 2): q[25] selects which bit is the leading one
  always_comb begin
    w_exp_base = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
               + (quo_q[25] ? 10'sd127 : 10'sd126);
    if (quo_q[25]) begin
      w_mant_pre = quo_q[25:2];
      w_guard    = quo_q[1];
      w_sticky   = quo_q[0] | (rem_q != 25'd0);
    end else begin
      w_mant_pre = quo_q[24:1];
      w_guard    = quo_q[0];
      w_sticky   = (rem_q != 25'd0);
    end
    w_inc      = w_guard & (w_sticky | w_mant_pre[0]);
    w_mant_sum = {1'b0, w_mant_pre} + {24'd0, w_inc};
    if (w_mant_sum[24]) begin
      w_mant_fin = 24'h800000;
      w_exp_fin  = w_exp_base + 10'sd1;
    end else begin
      w_mant_fin = w_mant_sum[23:0];
      w_exp_fin  = w_exp_base;
    end
    if (w_exp_fin >= 10'sd255) begin
      w_round_res = {sign_q, 8'hFF, 23'd0};
    end else if (w_exp_fin <= 10'sd0) begin
      w_round_res = {sign_q, 31'd0};
    end else begin
      w_round_res = {sign_q, w_exp_fin[7:0], w_mant_fin[22:0]};
    end
  end

  // Control FSM and datapath registers; done is a single-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'h00000000;
      sign_q   <= 1'b0;
      ea_q     <= 8'd0;
      eb_q     <= 8'd0;
      mb_q     <= 24'd0;
      rem_q    <= 25'd0;
      quo_q    <= 26'd0;
      cnt_q    <= 5'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sign_q <= w_sign;
            ea_q   <= operand_a[30:23];
            eb_q   <= operand_b[30:23];
            mb_q   <= {1'b1, operand_b[22:0]};
            rem_q  <= {2'b01, operand_a[22:0]};
            quo_q  <= 26'd0;
            cnt_q  <= 5'd0;
            if (w_special) begin
              result_q <= w_special_res;
              done_q   <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              state_q <= S_DIVIDE;
            end
          end
        end
        S_DIVIDE: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == C_LAST_ITER) begin
            state_q <= S_ROUND;
          end
        end
        S_ROUND: begin
          result_q <= w_round_res;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: doc/fp_div.md
# fp_div

Iterative IEEE-754 single-precision divider computing `result = operand_a / operand_b`. It is the inverse companion of the combinational `fp_mult` in the FPU. It uses a start/done handshake and produces one quotient bit per clock with a restoring-division datapath. Special operands are resolved in a single cycle, and normal operands complete in a fixed 27-cycle latency.

## Interface
- No parameters; format fixed at binary32.
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `operand_a`  in  32  dividend; captured on the accepting edge.
- `operand_b`  in  32  divisor; captured on the accepting edge.
- `busy`  out  1  high from the accepting edge until the edge that raises `done`.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  32  quotient; holds its value until the next `done`.

## Operation
- Reset values: `busy`=0, `done`=0, `result`=32'h00000000, state=IDLE.
- **States:** IDLE, DIVIDE, ROUND.
- **IDLE:** `start`=1 captures operands, sets `busy`=1, and sets sign = a[31]^b[31].
  - If a special case applies, next state is IDLE with `done`=1 and `result` set.
  - Otherwise, next state is DIVIDE, iteration counter = 0.
- **Special cases**, in priority order. Exponent 0 is treated as zero; denormal inputs are flushed.
  - Either operand NaN, 0/0, or inf/inf gives 32'h7FC00000.
  - inf/x gives signed infinity.
  - x/0 (x nonzero) gives signed infinity.
  - 0/x gives signed zero.
  - x/inf gives signed zero.
- **DIVIDE:** restoring division of ma = {1,a[22:0]} by mb = {1,b[22:0]}.
  - Remainder is 25 bits wide and is initialised to ma.
  - Each iteration: if rem ≥ mb, then q bit = 1 and rem = rem - mb; else q bit = 0. Then rem <<= 1.
  - 26 iterations produce q[25:0]: 1 integer bit and 25 fraction bits.
  - Counter values 0..25; after the counter-25 iteration, next state is ROUND.
- **ROUND:**
  - If q[25]=1: mant = q[25:2], guard = q[1], sticky = q[0] | (rem≠0), exp = ea - eb + 127.
  - Else: mant = q[24:1], guard = q[0], sticky = (rem≠0), exp = ea - eb + 126.
  - Round to nearest even: increment mant if guard & (sticky | mant[0]).
  - If the increment carries out of 24 bits: mant = 1.0 and exp += 1.
  - Exponent arithmetic is 10-bit signed.
  - exp ≥ 255 gives signed infinity; exp ≤ 0 gives signed zero (flush to zero). Otherwise result = {sign, exp[7:0], mant[22:0]}.
  - Then set `done`=1, `busy`=0, next state IDLE.
- `start` while `busy`=1 is ignored; operands and the in-flight computation are unaffected.
- `start`=1 in the same cycle that `done`=1: accepted, since `busy` is already 0.
- `rst` mid-operation aborts the computation. All outputs return to their reset values on that edge and no `done` is generated.

## Timing
- Let E0 be the edge where `start` is accepted.
- Special case: `done`=1 in the cycle following E0; latency 1.
- Normal case: E1..E26 perform the 26 iterations and E27 performs ROUND. `done`=1 in the cycle following E27; latency 27.
- `busy` is high in the cycles after E0 through E26 and low in the `done` cycle.
- `done` is registered, high for exactly one cycle.
- `result` is registered and changes only on the edge that asserts `done`.

## Test plan
- 40C00000 / 40000000 (6/2) -> 40400000; `done` exactly 27 cycles after accept; `busy` high for 27 cycles.
- 3F800000 / 40400000 (1/3) -> 3EAAAAAB (rounds up). BF800000 / 3F800000 -> BF800000.
- 3FC00000 / 00000000 -> 7F800000 at latency 1. 00000000 / 00000000 -> 7FC00000. 00000000 / BFC00000 -> 80000000.
- Overflow: 7F000000 / 00800000 -> 7F800000. Underflow: 00800000 / 7F000000 -> 00000000.
- Issue 40C00000 / 40000000, then pulse `start` with 3F800000 / 40400000 at cycle 5 -> single `done` with 40400000. Back-to-back `start` on the `done` cycle is accepted.
- Assert `rst` at cycle 10 of a divide -> `busy`=0, `done`=0, `result`=0 on the next cycle, with no `done` afterwards. A subsequent 40000000 / 40000000 -> 3F800000.
